rca_8_adder: RTL and testbench
==============================

// Module: rca_8_adder
//
// PURPOSE
// - 8-bit ripple-carry adder: s/cout = a + b + cin, built as a chain of eight 1-bit full adders.
// - The carry ripples from bit 0 to bit 7; cout is the carry out of bit 7.
// - Results are registered: one clock of latency, making the block drop-in for pipelined datapaths.
// - Leaf arithmetic block; no handshake, and it accepts a new operand set every cycle.
//
// PARAMETERS
// - none. Width is fixed at 8; the full-adder chain is 8 stages, bit 0 is the LSB.
//
// PORTS
// - One clock; reset is synchronous and active-high.
// clk   in   1  system clock; all state updates on rising edge
// rst   in   1  synchronous active-high reset
// a     in   8  operand A, unsigned (two's complement when overflow feature enabled)
// b     in   8  operand B
// cin   in   1  carry into bit 0
// s     out  8  registered sum bits [7:0]
// cout  out  1  registered carry out of bit 7
// ovf   out  1  registered signed overflow (only when RCA_8_ADDER_OVF_EN defined)
//
// BEHAVIOUR
// - Full-adder stage i (i = 0..7):
//   - sum_i   = a[i] ^ b[i] ^ c[i]
//   - c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
//   - c[0] = cin; cout_next = c[8].
// - The chain is pure combinational logic; no carry-lookahead or tree restructuring is used.
// - {cout_next, s_next} equals the 9-bit value a + b + cin exactly, for all 2^17 inputs.
// - Rising edge of clk:
//   - rst=1: s <= 8'h00, cout <= 0 (and ovf <= 0); operands are ignored.
//   - rst=0: s <= s_next, cout <= cout_next (and ovf <= ovf_next).
// - Latency: operands present before edge N appear on s/cout after edge N (1 cycle).
// - Throughput: 1 result per cycle; changing the inputs every cycle is legal.
// - Wrap-around: the sum is modulo 256 and the carry is reported on cout.
//   - Example: 8'hFF + 8'h00 + 1 -> s=8'h00, cout=1.
// - Reset mid-stream: a result in flight is discarded; the first valid result is one cycle after rst deasserts.
// - Outputs hold their value between edges; no combinational path from inputs to outputs.
// - Timing: the critical path is cin -> c[8] through 8 stages; no multicycle constraints.
//
// CONFIGURATION
// - Macro RCA_8_ADDER_OVF_EN:
//   - Defined: port ovf exists. ovf_next = c[8] ^ c[7], i.e. two's-complement overflow of a+b+cin.
//     ovf is registered like s, and cleared by rst.
//   - Undefined: no ovf port, no overflow logic; all other behaviour is identical.
//
// TESTING
// - rst=1 for 2 cycles with a=8'hFF, b=8'hFF, cin=1 -> s=8'h00, cout=0 (ovf=0) after each edge.
// - a=8'h50, b=8'h00, cin=1 -> one cycle later s=8'h51, cout=0.
// - a=8'hD0, b=8'h4C, cin=0 -> s=8'h1C, cout=1; with OVF_EN ovf=0.
// - a=8'hF0, b=8'h5C, cin=1 -> s=8'h4D, cout=1.
// - a=8'hFF, b=8'h00, cin=1 -> s=8'h00, cout=1 (full ripple); a=8'h7F, b=8'h01, cin=0 -> s=8'h80, cout=0, ovf=1.
// - Back-to-back random operands every cycle plus rst pulsed mid-stream -> each output equals the
//   golden a+b+cin from the prior cycle, and is zero on the edge after rst.

Source files
------------

// File: rtl/rca_8_adder_if.sv
// ---------------------------------------------------------------------------
// rca_8_adder_if : operand/result bundle for the 8-bit ripple-carry adder.
// The operands are a, b and cin. The registered results are s, cout and,
// when RCA_8_ADDER_OVF_EN is defined, ovf.
// The master drives the operands and the slave (the adder) drives the results.
// ---------------------------------------------------------------------------
interface rca_8_adder_if;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic [7:0] s;
   logic       cout;
`ifdef RCA_8_ADDER_OVF_EN
   logic       ovf;

   modport master (output a, output b, output cin,
                   input  s, input  cout, input ovf);
   modport slave  (input  a, input  b, input  cin,
                   output s, output cout, output ovf);
`else
   modport master (output a, output b, output cin,
                   input  s, input  cout);
   modport slave  (input  a, input  b, input  cin,
                   output s, output cout);
`endif
endinterface

// File: rtl/rca_8_adder.sv
// ---------------------------------------------------------------------------
// rca_8_adder : 8-bit ripple-carry adder with registered outputs.
// - The adder is a chain of eight 1-bit full adders. The carry ripples from
//   bit 0 to bit 7, and there is no lookahead.
// - Results appear one clock after the operands.
// - rst is synchronous and active-high. It clears all result registers.
// - Optional macro RCA_8_ADDER_OVF_EN adds a registered two's-complement
//   overflow flag, ovf = c[8] ^ c[7].
// ---------------------------------------------------------------------------
module rca_8_adder (
   input  logic         clk,
   input  logic         rst,
   rca_8_adder_if.slave bus
);

   // One full-adder stage. The result is packed as {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a_bit,
                                           input logic b_bit,
                                           input logic c_bit);
      logic sum_bit;
      logic carry_bit;
      sum_bit   = a_bit ^ b_bit ^ c_bit;
      carry_bit = (a_bit & b_bit) | (c_bit & (a_bit ^ b_bit));
      return {carry_bit, sum_bit};
   endfunction

   logic [8:0] carry;
   logic [7:0] s_d;
   logic [7:0] s_q;
   logic       cout_d;
   logic       cout_q;

   // Ripple the carry through the eight full-adder stages, from the LSB upward.
   always_comb begin
      logic [1:0] fa;
      fa       = 2'b00;
      s_d      = 8'h00;
      carry    = 9'h000;
      carry[0] = bus.cin;
      for (int i = 0; i < 8; i++) begin
         fa           = full_add(bus.a[i], bus.b[i], carry[i]);
         s_d[i]       = fa[0];
         carry[i + 1] = fa[1];
      end
      cout_d = carry[8];
   end

   // Capture the sum and carry-out each cycle. A reset discards any result in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= 8'h00;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign bus.s    = s_q;
   assign bus.cout = cout_q;

`ifdef RCA_8_ADDER_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Signed overflow occurs when the carry into the sign bit differs from the carry out of it.
   always_comb begin
      ovf_d = carry[8] ^ carry[7];
   end

   // Register the overflow flag alongside the sum, with the same reset behaviour.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_8_adder.sv
// ---------------------------------------------------------------------------
// tb_rca_8_adder : scoreboard bench for rca_8_adder.
// The stimulus process drives operands on the falling edge and queues the
// expected result. The monitor pops and compares one clock later, just after
// the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rca_8_adder;

   typedef struct {
      int         id;
      logic [7:0] s;
      logic       cout;
      logic       ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];

   rca_8_adder_if bus_if ();

   rca_8_adder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one operand set and queue the expected registered result.
   task automatic drive(input int id, input logic r, input logic [7:0] a,
                        input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo);
      exp_t e;
      @(negedge clk);
      rst        = r;
      bus_if.a   = a;
      bus_if.b   = b;
      bus_if.cin = c;
      e.id   = id;
      e.s    = es;
      e.cout = ec;
      e.ovf  = eo;
      exp_q.push_back(e);
   endtask

   // Monitor: pop one expectation per clock and compare it with the DUT outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus_if.s !== e.s) begin
               n_fail++;
               $display("FAIL sum[%0d]: got %h expected %h", e.id, bus_if.s, e.s);
            end
            n_checks++;
            if (bus_if.cout !== e.cout) begin
               n_fail++;
               $display("FAIL cout[%0d]: got %b expected %b", e.id, bus_if.cout, e.cout);
            end
`ifdef RCA_8_ADDER_OVF_EN
            n_checks++;
            if (bus_if.ovf !== e.ovf) begin
               n_fail++;
               $display("FAIL ovf[%0d]: got %b expected %b", e.id, bus_if.ovf, e.ovf);
            end
`endif
         end
      end
   end

   // Stimulus: directed vectors first, then a random stream with a mid-stream reset.
   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] gold;
      int         sgn;
      logic       gov;
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      bus_if.a   = 8'h00;
      bus_if.b   = 8'h00;
      bus_if.cin = 1'b0;

      // Hold reset with all-ones operands; outputs must stay zero.
      drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
      drive(1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
      // Directed vectors with hand-computed results.
      drive(2, 1'b0, 8'h50, 8'h00, 1'b1, 8'h51, 1'b0, 1'b0);
      drive(3, 1'b0, 8'hD0, 8'h4C, 1'b0, 8'h1C, 1'b1, 1'b0);
      drive(4, 1'b0, 8'hF0, 8'h5C, 1'b1, 8'h4D, 1'b1, 1'b0);
      drive(5, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      drive(6, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      drive(7, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      drive(8, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      drive(9, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(10, 1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

      // Random back-to-back operands, with a reset pulse in the middle of the stream.
      for (int i = 0; i < 40; i++) begin
         ra   = 8'($urandom_range(255, 0));
         rb   = 8'($urandom_range(255, 0));
         rc   = 1'($urandom_range(1, 0));
         gold = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         sgn  = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
         gov  = (sgn > 127) || (sgn < -128);
         if (i == 20 || i == 21) begin
            drive(100 + i, 1'b1, ra, rb, rc, 8'h00, 1'b0, 1'b0);
         end else begin
            drive(100 + i, 1'b0, ra, rb, rc, gold[7:0], gold[8], gov);
         end
      end

      // Wait a bounded number of cycles for the scoreboard to drain.
      for (int k = 0; k < 10; k++) begin
         if (exp_q.size() > 0) begin
            @(posedge clk);
            #2;
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
